weight_loader: RTL and testbench

WEIGHT_LOADER -- requirements
Module: weight_loader

---
 rtl/weight_loader.sv | 135 +++++++++++++
 tb/tb_weight_loader.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/weight_loader.sv
// Weight loader: accepts a row-major weight stream, stages one row at a time
// and strobes it into the systolic array row by row.

// One staging register per column; holds its value until that column is rewritten.
module weight_slot #(
  parameter int WEIGHT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr,
  input  logic [WEIGHT_WIDTH-1:0] d,
  output logic [WEIGHT_WIDTH-1:0] q
);
  // Capture the beat when this slot is addressed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (wr) q <= d;
  end
endmodule

module weight_loader #(
  parameter int WEIGHT_WIDTH = 8,
  parameter int N            = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           abort,
  input  logic                           w_valid,
  output logic                           w_ready,
  input  logic signed [WEIGHT_WIDTH-1:0] w_data,
  output logic [N*WEIGHT_WIDTH-1:0]      weight_o,
  output logic [N-1:0]                   load_en_o,
  output logic                           busy,
  output logic                           done
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N-1);

  typedef enum logic [1:0] {IDLE, FILL, COMMIT, DONE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] col_cnt, col_nx, row_cnt, row_nx;
  logic          accept;
  logic [N-1:0]  wr_en;

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      col_cnt <= '0;
      row_cnt <= '0;
    end else begin
      state   <= state_nx;
      col_cnt <= col_nx;
      row_cnt <= row_nx;
    end
  end

  // Next-state and outputs; abort in any busy state masks every strobe
  // for that cycle and returns to IDLE with the counters cleared.
  always_comb begin
    state_nx  = state;
    col_nx    = col_cnt;
    row_nx    = row_cnt;
    w_ready   = 1'b0;
    load_en_o = '0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nx = FILL;
          col_nx   = '0;
          row_nx   = '0;
        end
      end
      FILL: begin
        if (abort) begin
          state_nx = IDLE;
          col_nx   = '0;
          row_nx   = '0;
        end else begin
          w_ready = 1'b1;
          if (w_valid) begin
            accept = 1'b1;
            if (col_cnt == LAST) begin
              col_nx   = '0;
              state_nx = COMMIT;
            end else begin
              col_nx = col_cnt + 1'b1;
            end
          end
        end
      end
      COMMIT: begin
        if (abort) begin
          state_nx = IDLE;
          col_nx   = '0;
          row_nx   = '0;
        end else begin
          load_en_o = N'(1) << row_cnt;
          if (row_cnt == LAST) begin
            state_nx = DONE;
          end else begin
            row_nx   = row_cnt + 1'b1;
            state_nx = FILL;
          end
        end
      end
      DONE: begin
        done     = !abort;
        state_nx = IDLE;
        col_nx   = '0;
        row_nx   = '0;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Per-column staging; weight_o is the raw register contents, so after a
  // commit it shows a mix of old and new weights until the row refills.
  for (genvar c = 0; c < N; c++) begin : g_slot
    assign wr_en[c] = accept && (col_cnt == CW'(c));
    weight_slot #(.WEIGHT_WIDTH(WEIGHT_WIDTH)) u_slot (
      .clk (clk),
      .rst (rst),
      .wr  (wr_en[c]),
      .d   (w_data),
      .q   (weight_o[c*WEIGHT_WIDTH +: WEIGHT_WIDTH])
    );
  end
endmodule

// File: tb/tb_weight_loader.sv
// Randomized bench for weight_loader against a beat-count reference model.
module tb_weight_loader;
  localparam int N = 4;
  localparam int W = 8;

  logic                  clk = 1'b0;
  logic                  rst, start, abort, w_valid;
  logic signed [W-1:0]   w_data;
  logic                  w_ready, busy, done;
  logic [N*W-1:0]        weight_o;
  logic [N-1:0]          load_en_o;

  always #5 clk = ~clk;

  weight_loader #(.WEIGHT_WIDTH(W), .N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .weight_o(weight_o), .load_en_o(load_en_o), .busy(busy), .done(done)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a load is N*N beats; after every N-th accepted beat the
  // next cycle is a commit of that row, after the last commit a done cycle.
  bit          loading, pend_commit, pend_done, full_rate;
  int          k, ecount;
  logic [W-1:0] stg [N];
  logic [W-1:0] mem [N*N];

  function automatic logic [N*W-1:0] pack_stg();
    logic [N*W-1:0] p;
    for (int c = 0; c < N; c++) p[c*W +: W] = stg[c];
    return p;
  endfunction

  function automatic logic [N*W-1:0] pack_row(input int r);
    logic [N*W-1:0] p;
    for (int c = 0; c < N; c++) p[c*W +: W] = mem[r*N + c];
    return p;
  endfunction

  task automatic model_reset();
    loading = 0; pend_commit = 0; pend_done = 0; k = 0;
    for (int c = 0; c < N; c++) stg[c] = '0;
  endtask

  task automatic check_outs();
    logic [N-1:0] exp_le;
    int           row;
    row    = k / N - 1;
    exp_le = (loading && pend_commit && !abort) ? (N'(1) << row) : '0;
    chk("busy",      64'(busy),      64'(loading));
    chk("w_ready",   64'(w_ready),   64'(loading && !pend_commit && !pend_done && !abort));
    chk("load_en",   64'(load_en_o), 64'(exp_le));
    chk("done",      64'(done),      64'(loading && pend_done && !abort));
    chk("weight_o",  64'(weight_o),  64'(pack_stg()));
    if (exp_le != '0) begin
      chk("commit_row", 64'(weight_o), 64'(pack_row(row)));
      if (full_rate) chk("commit_cyc", 64'(ecount + 1), 64'((row + 1) * (N + 1)));
    end
    if (full_rate && loading && pend_done && !abort)
      chk("done_cyc", 64'(ecount + 1), 64'(N * (N + 1) + 1));
  endtask

  task automatic model_step();
    ecount++;
    if (!loading) begin
      if (start && !abort) begin
        loading = 1; k = 0; pend_commit = 0; pend_done = 0; ecount = 0;
      end
    end else if (abort) begin
      loading = 0; pend_commit = 0; pend_done = 0; k = 0;
    end else if (pend_commit) begin
      pend_commit = 0;
      if (k == N * N) pend_done = 1;
    end else if (pend_done) begin
      pend_done = 0; loading = 0;
    end else if (w_valid) begin
      mem[k]     = w_data;
      stg[k % N] = w_data;
      k++;
      if (k % N == 0) pend_commit = 1;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic step(input bit s, input bit a, input bit v, input logic [W-1:0] d);
    start = s; abort = a; w_valid = v; w_data = d;
    cycle();
  endtask

  // Reset pulsed between edges: outputs must clear without waiting for a clock.
  task automatic do_reset();
    start = 0; abort = 0; w_valid = 0;
    #2 rst = 1;
    #1;
    model_reset();
    chk("rst_weight", 64'(weight_o), 64'(0));
    chk("rst_le",     64'(load_en_o), 64'(0));
    chk("rst_ready",  64'(w_ready), 64'(0));
    chk("rst_busy",   64'(busy), 64'(0));
    chk("rst_done",   64'(done), 64'(0));
    @(posedge clk); #1;
    chk("rst_hold_busy", 64'(busy), 64'(0));
    #2 rst = 0;
  endtask

  initial begin
    rst = 1; start = 0; abort = 0; w_valid = 0; w_data = '0; full_rate = 0; ecount = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("init_weight", 64'(weight_o), 64'(0));
    chk("init_le",     64'(load_en_o), 64'(0));
    chk("init_busy",   64'(busy), 64'(0));
    #2 rst = 0;

    // Full-rate load of 1..16.
    full_rate = 1;
    step(1, 0, 0, 0);
    for (int i = 0; i < N * (N + 1) + 2; i++) step(0, 0, 1, W'(k + 1));
    full_rate = 0;

    // Extreme values keep their bit patterns.
    step(1, 0, 0, 0);
    step(0, 0, 1, 8'h80);
    chk("neg_min", 64'(weight_o[W-1:0]), 64'(8'h80));
    step(0, 0, 1, 8'h7F);
    chk("pos_max", 64'(weight_o[2*W-1:W]), 64'(8'h7F));
    for (int i = 0; i < N * (N + 1); i++) step(0, 0, 1, W'($urandom));
    repeat (3) step(0, 0, 0, 0);

    // Abort after 6 beats (beat on the abort cycle is dropped), then a fresh load.
    step(1, 0, 0, 0);
    for (int i = 0; i < N + 3; i++) step(0, 0, 1, W'(8'h40 + k));
    step(0, 1, 1, 8'hAA);
    chk("abort_idle", 64'(busy), 64'(0));
    repeat (3) step(0, 0, 1, 8'h55);
    step(1, 1, 0, 0);
    chk("start_abort_idle", 64'(busy), 64'(0));
    full_rate = 1;
    step(1, 0, 0, 0);
    for (int i = 0; i < N * (N + 1) + 2; i++) step(0, 0, 1, W'(8'h20 + k));
    full_rate = 0;

    // Reset during row 2 fill.
    step(1, 0, 0, 0);
    for (int i = 0; i < 2 * (N + 1) + 2; i++) step(0, 0, 1, W'($urandom));
    do_reset();
    repeat (4) step(0, 0, 1, W'($urandom));

    // Start held across a whole load.
    for (int i = 0; i < 2 * N * (N + 1) + 6; i++) step(1, 0, 1, W'($urandom));
    step(0, 0, 0, 0);
    for (int i = 0; i < N * (N + 1) + 4; i++) step(0, 0, 1, W'($urandom));

    // Randomized traffic with gaps, aborts and resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      else step($urandom_range(0, 9) == 0, $urandom_range(0, 59) == 0,
                $urandom_range(0, 9) < 7, W'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
